// File: rtl/draw_pkg.sv
// Shared types and screen defaults for the draw sequencer slice.
package draw_pkg;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    typedef logic [2:0] colour_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL_RST,
        FILL,
        CIRC_RST,
        CIRC,
        DONE
    } state_t;

endpackage

// File: rtl/draw_sequencer_pixel_clip.sv
// Signed on-screen test for one pixel coordinate pair.
module pixel_clip
    import draw_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic signed [8:0] x,
    input  logic signed [7:0] y,
    output logic              valid
);

    localparam logic signed [8:0] X_MAX = 9'(SCREEN_W - 1);
    localparam logic signed [7:0] Y_MAX = 8'(SCREEN_H - 1);

    assign valid = !x[8] && !y[7] && (x <= X_MAX) && (y <= Y_MAX);

endmodule

// File: rtl/draw_sequencer.sv
// Runs clear-then-circle jobs, muxes child pixel streams, clips and registers to VGA.
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    input  logic [2:0] colour,
    output logic       done,
    output logic       fill_rst_n,
    output logic       fill_start,
    input  logic       fill_done,
    input  logic [7:0] fill_x,
    input  logic [6:0] fill_y,
    input  logic [2:0] fill_colour,
    input  logic       fill_plot,
    output logic       circ_rst_n,
    output logic       circ_start,
    input  logic       circ_done,
    output logic [7:0] circ_centre_x,
    output logic [6:0] circ_centre_y,
    output logic [7:0] circ_radius,
    output logic [2:0] circ_colour,
    input  logic [8:0] circ_x,
    input  logic [7:0] circ_y,
    input  logic       circ_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    state_t            state;
    state_t            nxt;
    logic              in_fill;
    logic              in_circ;
    logic signed [8:0] sel_x;
    logic signed [7:0] sel_y;
    colour_t           sel_c;
    logic              sel_v;
    logic              on_screen;

    // Gating with start drops the pixel in flight on an abort.
    assign in_fill = (state == FILL) && start;
    assign in_circ = (state == CIRC) && start;

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        sel_v = 1'b0;
        unique case (1'b1)
            in_fill: begin
                sel_x = {1'b0, fill_x};
                sel_y = {1'b0, fill_y};
                sel_c = fill_colour;
                sel_v = fill_plot;
            end
            in_circ: begin
                sel_x = circ_x;
                sel_y = circ_y;
                sel_c = circ_colour;
                sel_v = circ_plot;
            end
            default: ;
        endcase
    end

    pixel_clip #(
        .SCREEN_W(SCREEN_W),
        .SCREEN_H(SCREEN_H)
    ) u_clip (
        .x    (sel_x),
        .y    (sel_y),
        .valid(on_screen)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     if (start) nxt = FILL_RST;
            FILL_RST: nxt = start ? FILL : IDLE;
            FILL: begin
                if (!start)         nxt = IDLE;
                else if (fill_done) nxt = CIRC_RST;
            end
            CIRC_RST: nxt = start ? CIRC : IDLE;
            CIRC: begin
                if (!start)         nxt = IDLE;
                else if (circ_done) nxt = DONE;
            end
            DONE:     if (!start) nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // Child controls are decoded from the state being entered so they register with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            done          <= 1'b0;
            fill_rst_n    <= 1'b0;
            fill_start    <= 1'b0;
            circ_rst_n    <= 1'b0;
            circ_start    <= 1'b0;
            circ_centre_x <= '0;
            circ_centre_y <= '0;
            circ_radius   <= '0;
            circ_colour   <= '0;
        end else begin
            state      <= nxt;
            done       <= (nxt == DONE);
            fill_rst_n <= (nxt == FILL) || (nxt == CIRC_RST) ||
                          (nxt == CIRC) || (nxt == DONE);
            fill_start <= (nxt == FILL);
            circ_rst_n <= (nxt == CIRC) || (nxt == DONE);
            circ_start <= (nxt == CIRC);
            if (state == IDLE && start) begin
                circ_centre_x <= centre_x;
                circ_centre_y <= centre_y;
                circ_radius   <= radius;
                circ_colour   <= colour;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= sel_v && on_screen;
            if (sel_v && on_screen) begin
                vga_x      <= sel_x[7:0];
                vga_y      <= sel_y[6:0];
                vga_colour <= sel_c;
            end
        end
    end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Sits directly downstream of the fillscreen stage and the circle stage, feeding the VGA adapter's plot port. It runs one drawing job per `start`: it clears the screen via fillscreen, then draws one circle. It owns the sub-stages' resets and start lines, multiplexes their pixel streams, clips off-screen pixels, and registers the result onto the VGA port. The circle stage plots in the caller-supplied colour; fillscreen always plots black.

## Interface
- `SCREEN_W`, default 160: visible width in pixels.
- `SCREEN_H`, default 120: visible height in pixels.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  level; job runs while high.
- `centre_x`  in  8  circle centre x, sampled at job start.
- `centre_y`  in  7  circle centre y, sampled at job start.
- `radius`  in  8  circle radius, sampled at job start.
- `colour`  in  3  circle colour, sampled at job start.
- `done`  out  1  job complete; held until `start` falls.
- `fill_rst_n`  out  1  fillscreen reset.
- `fill_start`  out  1  fillscreen start.
- `fill_done`  in  1  fillscreen done.
- `fill_x`  in  8  fillscreen pixel x.
- `fill_y`  in  7  fillscreen pixel y.
- `fill_colour`  in  3  fillscreen pixel colour.
- `fill_plot`  in  1  fillscreen pixel valid.
- `circ_rst_n`  out  1  circle stage reset.
- `circ_start`  out  1  circle stage start.
- `circ_done`  in  1  circle stage done.
- `circ_centre_x`  out  8  registered `centre_x`.
- `circ_centre_y`  out  7  registered `centre_y`.
- `circ_radius`  out  8  registered `radius`.
- `circ_colour`  out  3  registered `colour`.
- `circ_x`  in  9  signed circle pixel x.
- `circ_y`  in  8  signed circle pixel y.
- `circ_plot`  in  1  circle pixel valid.
- `vga_x`  out  8  pixel x to adapter.
- `vga_y`  out  7  pixel y to adapter.
- `vga_colour`  out  3  pixel colour to adapter.
- `vga_plot`  out  1  pixel write strobe.

## Operation
- States: `IDLE`, `FILL_RST`, `FILL`, `CIRC_RST`, `CIRC`, `DONE`.
- `IDLE`:
  - both child resets low, both child starts low.
  - When `start`=1: latch the `circ_*` parameters and go to `FILL_RST`.
- `FILL_RST`: `fill_rst_n`=0 for exactly one cycle, then `FILL`.
- `FILL`:
  - `fill_rst_n`=1, `fill_start`=1; the fill stream is selected.
  - When `fill_done`=1: go to `CIRC_RST`.
- `CIRC_RST`: `circ_rst_n`=0 for one cycle, `fill_start`=0, then `CIRC`.
- `CIRC`:
  - `circ_rst_n`=1, `circ_start`=1; the circle stream is selected.
  - When `circ_done`=1: go to `DONE`.
- `DONE`: `done`=1, child starts low; when `start`=0, go to `IDLE`.
- Abort: `start`=0 in any state other than `IDLE` or `DONE` sends the FSM to `IDLE` next cycle. The pixel in flight is dropped.
- Stream selection:
  - `FILL` selects the fill stream; `CIRC` selects the circle stream.
  - In all other states the selected valid is 0.
- Clipping:
  - The selected pixel is widened to signed 9-bit x and signed 8-bit y.
  - Valid only if 0 ≤ x ≤ `SCREEN_W`-1 and 0 ≤ y ≤ `SCREEN_H`-1.
  - Fill x=255 (its pre-first-pixel count) and circle octant points off any edge are dropped.
  - Clipped pixels never assert `vga_plot`.

## Timing
- Reset values (while `rst_n`=0 and on the first cycle after):
  - state `IDLE`; `done`=0; `vga_plot`=0.
  - `vga_x`=0, `vga_y`=0, `vga_colour`=0.
  - `fill_rst_n`=0, `circ_rst_n`=0, `fill_start`=0, `circ_start`=0.
  - All `circ_*` parameter outputs = 0.
- Pixel path latency: selected input at edge N appears on `vga_*` at edge N+1, with one register stage.
- `vga_x`, `vga_y` and `vga_colour` update only when the clipped pixel is valid. Otherwise they hold and `vga_plot`=0.
- `start` to first `fill_start`: 2 cycles (`IDLE`→`FILL_RST`→`FILL`).
- `fill_done` to `circ_start`: 2 cycles.
- `circ_done` to `done`: 1 cycle.
- Child starts and resets are registered outputs of the FSM.
- A `fill_done` or `circ_done` arriving in the wrong state is ignored.

## Structure
- Package `draw_pkg` holds:
  - the `state_t` enum;
  - `SCREEN_W` and `SCREEN_H` defaults;
  - `colour_t` (3-bit).
- Sub-module `pixel_clip`: combinational signed bounds check on (x, y), returning a valid bit. It is instantiated once, on the muxed stream.

## Test plan
- Full job with behavioural child models:
  - fill emits 160×120 pixels, then circle at (80,60) r=10, colour 3'b010.
  - Required: exactly 19200 black plots, then circle plots in colour 010, then `done`=1.
- Clip at x=255:
  - fill stream emits x=255, y=0, plot=1.
  - Required: `vga_plot` stays 0 on the following cycle.
- Edge circle at (0,0) r=20: every `vga_plot` pixel has x ≤ 159 and y ≤ 119, and no negative pixel is plotted.
- Abort:
  - drop `start` mid-`FILL` at pixel 5000.
  - Required: `IDLE` next cycle, `vga_plot`=0, `fill_rst_n`=0.
  - Restart re-clears from (0,0).
- Reset mid-`CIRC`: `rst_n`=0 for one cycle gives all outputs at their reset values on the next edge.
- Handshake:
  - holding `start`=1 after `done` keeps `done`=1 and starts no new job.
  - `start`=0→1 runs a second job with newly latched parameters.
